// File: rtl/decoder_3_8_pulse.sv
// Queued 3-to-8 decoder: buffers encoded indices and replays each one as a
// one-hot strobe held for PULSE_LEN cycles, with one idle cycle between strobes.
module decoder_3_8_pulse #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_code,
  input  logic                     in_v,
  input  logic                     flush,
  output logic [7:0]               y,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      y_q, y_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [2:0]      mem_q [DEPTH];

  logic full, empty, push, pop;

  // Valid/ready: a beat transfers at a rising edge when in_valid && in_ready.
  // in_ready depends only on registered occupancy, flush and reset, never on in_valid.
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign in_ready = rst_n && !full && !flush;
  assign push     = in_valid && in_ready && in_v;
  assign pop      = !flush && !empty && ((state_q == IDLE) || (state_q == GAP));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      y_d      = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      case (state_q)
        IDLE, GAP: begin
          if (pop) begin
            state_d = DRIVE;
            y_d     = 8'd1 << mem_q[rd_ptr_q];
            cnt_d   = 8'(PULSE_LEN - 1);
          end else begin
            state_d = IDLE;
          end
        end
        DRIVE: begin
          if (cnt_q == 8'd0) begin
            state_d = GAP;
            y_d     = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          y_d     = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      y_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end

  assign y         = y_q;
  assign done      = (state_q == DRIVE) && (cnt_q == 8'd0);
  assign busy      = (state_q != IDLE) || !empty;
  assign level     = level_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_decoder_3_8_pulse.sv
// Directed bench for decoder_3_8_pulse: cycle table, burst/flush/reset
// sequences on a PULSE_LEN=4 instance, and a PULSE_LEN=1 instance.
module tb_decoder_3_8_pulse;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_v, flush;
  logic [2:0] in_code;
  logic       in_ready, done, busy;
  logic [7:0] y;
  logic [2:0] level;
  logic [1:0] dbg_state;

  logic       p1_valid, p1_v, p1_flush;
  logic [2:0] p1_code;
  logic       p1_ready, p1_done, p1_busy;
  logic [7:0] p1_y;
  logic [2:0] p1_level;
  logic [1:0] p1_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  decoder_3_8_pulse #(.PULSE_LEN(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_v(in_v), .flush(flush), .y(y), .done(done),
    .busy(busy), .level(level), .dbg_state(dbg_state)
  );

  decoder_3_8_pulse #(.PULSE_LEN(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p1_valid), .in_ready(p1_ready),
    .in_code(p1_code), .in_v(p1_v), .flush(p1_flush), .y(p1_y), .done(p1_done),
    .busy(p1_busy), .level(p1_level), .dbg_state(p1_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor on the PULSE_LEN=4 instance
  logic [7:0] y_prev = '0;
  int         run = 0;
  int         cyc = 0;
  int         last_onset = 0;
  bit         have_onset = 0;
  bit         len_en = 1;
  bit         gap_en = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      y_prev = '0;
      run    = 0;
    end else begin
      if (y !== y_prev) begin
        if (y != 8'd0) begin
          if (exp_q.size() == 0) check("unexpected_pulse", {24'd0, y}, 32'd0);
          else check("pulse_order", {24'd0, y}, {24'd0, exp_q.pop_front()});
          if (gap_en && have_onset) check("pulse_period", cyc - last_onset, 5);
          last_onset = cyc;
          have_onset = 1;
          run = 1;
        end else if (len_en) begin
          check("pulse_len", run, 4);
        end
      end else if (y != 8'd0) begin
        run++;
      end
      y_prev = y;
    end
  end

  typedef struct {
    logic       valid;
    logic [2:0] code;
    logic       v;
    logic [7:0] exp_y;
    logic       exp_done;
    logic [2:0] exp_level;
    logic       exp_busy;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit saw_full;
    bit accepted;
    int k;
    int budget;

    // single code 5, then in_v=0 filtering (code 3 dropped, code 6 pulsed)
    tbl[0]  = '{1'b1, 3'd5, 1'b1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 3'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3'd6, 1'b1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 3'd0, 1'b0, 8'h40, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 3'd0, 1'b0, 8'h40, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 3'd0, 1'b0, 8'h40, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 1'b0, 8'h40, 1'b1, 3'd0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; in_code = '0; in_v = 1'b0; flush = 1'b0;
    p1_valid = 1'b0; p1_code = '0; p1_v = 1'b0; p1_flush = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    #3 rst_n = 1'b1;
    #1 check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // table-driven cycles
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h40);
    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].valid;
      in_code  = tbl[i].code;
      in_v     = tbl[i].v;
      tick();
      check($sformatf("tbl%0d_y", i), {24'd0, y}, {24'd0, tbl[i].exp_y});
      check($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].exp_done});
      check($sformatf("tbl%0d_level", i), {29'd0, level}, {29'd0, tbl[i].exp_level});
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
      check($sformatf("tbl%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_ready});
    end
    in_valid = 1'b0;
    check("tbl_sb_empty", exp_q.size(), 0);

    // burst of six codes into a four-entry FIFO
    have_onset = 0;
    gap_en = 1;
    for (int c = 0; c < 6; c++) exp_q.push_back(8'd1 << c);
    saw_full = 0;
    k = 0;
    budget = 0;
    in_valid = 1'b1;
    in_v = 1'b1;
    while (k < 6 && budget < 60) begin
      in_code  = 3'(k);
      accepted = in_ready;
      tick();
      budget++;
      if (accepted) k++;
      if (level == 3'd4) saw_full = 1;
      check("burst_level_bound", {31'd0, (level <= 3'd4)}, 32'd1);
      check("burst_ready", {31'd0, in_ready}, {31'd0, (level != 3'd4)});
    end
    in_valid = 1'b0;
    check("burst_all_accepted", k, 6);
    check("burst_saw_full", {31'd0, saw_full}, 32'd1);
    budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 80) begin
      tick();
      budget++;
    end
    check("burst_drain_timeout", {31'd0, (budget < 80)}, 32'd1);
    check("burst_sb_empty", exp_q.size(), 0);
    gap_en = 0;

    // flush during the second cycle of the code-1 pulse
    len_en = 0;
    exp_q.push_back(8'h02);
    in_valid = 1'b1; in_v = 1'b1; in_code = 3'd1;
    tick();
    in_code = 3'd2;
    tick();
    check("flush_pulse_c1", {24'd0, y}, 32'h02);
    in_code = 3'd7;
    tick();
    check("flush_pre_level", {29'd0, level}, 32'd2);
    in_valid = 1'b0;
    flush = 1'b1;
    #1 check("flush_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    check("flush_y", {24'd0, y}, 32'd0);
    check("flush_level", {29'd0, level}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (12) tick();
    check("flush_no_more_y", {24'd0, y}, 32'd0);
    check("flush_sb_empty", exp_q.size(), 0);

    // asynchronous reset during a y=8'h80 pulse, code 3 still queued
    in_valid = 1'b1; in_v = 1'b1; in_code = 3'd7;
    tick();
    in_code = 3'd3;
    tick();
    in_valid = 1'b0;
    check("arst_pulse_c7", {24'd0, y}, 32'h80);
    check("arst_queued", {29'd0, level}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y_immediate", {24'd0, y}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd0);
    check("arst_level", {29'd0, level}, 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    repeat (10) tick();
    check("arst_no_stale_y", {24'd0, y}, 32'd0);
    check("arst_level_after", {29'd0, level}, 32'd0);
    check("arst_busy_after", {31'd0, busy}, 32'd0);
    len_en = 1;

    // PULSE_LEN=1 instance: duplicate code 2 back-to-back
    p1_valid = 1'b1; p1_v = 1'b1; p1_code = 3'd2;
    tick();
    check("p1_e0_y", {24'd0, p1_y}, 32'd0);
    check("p1_e0_level", {29'd0, p1_level}, 32'd1);
    tick();
    p1_valid = 1'b0;
    check("p1_e1_y", {24'd0, p1_y}, 32'h04);
    check("p1_e1_done", {31'd0, p1_done}, 32'd1);
    tick();
    check("p1_e2_y", {24'd0, p1_y}, 32'd0);
    check("p1_e2_done", {31'd0, p1_done}, 32'd0);
    check("p1_e2_busy", {31'd0, p1_busy}, 32'd1);
    tick();
    check("p1_e3_y", {24'd0, p1_y}, 32'h04);
    check("p1_e3_done", {31'd0, p1_done}, 32'd1);
    tick();
    check("p1_e4_y", {24'd0, p1_y}, 32'd0);
    tick();
    check("p1_e5_busy", {31'd0, p1_busy}, 32'd0);
    check("p1_e5_level", {29'd0, p1_level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
